// File: rtl/bus_demux_pkg.sv
// Shared types and constants for the four-port memory bus demultiplexer.
package bus_demux_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE    = 2'd1,
        WAIT_RSP = 2'd2
    } demux_state_t;

    typedef logic [1:0] port_sel_t;

    localparam port_sel_t PORT_ROM   = 2'd0;
    localparam port_sel_t PORT_RAM   = 2'd1;
    localparam port_sel_t PORT_MMIO  = 2'd2;
    localparam port_sel_t PORT_SPARE = 2'd3;

    // One-hot request strobe for a given target index.
    function automatic logic [3:0] sel_onehot(input port_sel_t sel);
        return 4'b0001 << sel;
    endfunction

endpackage

// File: rtl/multiplexer4.sv
// Plain 4:1 combinational multiplexer used to pick the returning target's read data.
module multiplexer4 #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [WIDTH-1:0] in3,
    input  logic [1:0]       sel,
    output logic [WIDTH-1:0] out
);

    // Select one of the four inputs.
    always_comb begin
        out = in0;
        case (sel)
            2'd0:    out = in0;
            2'd1:    out = in1;
            2'd2:    out = in2;
            default: out = in3;
        endcase
    end

endmodule

// File: rtl/bus_demux4.sv
// Routes a single outstanding core request to one of four targets (ROM, RAM, MMIO, spare),
// returns that target's response, and raises a bus error if the target takes too long.
module bus_demux4
    import bus_demux_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int SEL_LSB    = 28,
    parameter int TIMEOUT    = 15
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic                    req_write,
    input  logic [WIDTH-1:0]        req_wdata,
    input  logic [WIDTH/8-1:0]      req_wmask,
    output logic                    rsp_valid,
    output logic [WIDTH-1:0]        rsp_rdata,
    output logic                    rsp_error,
    output logic [3:0]              port_req_valid,
    input  logic [3:0]              port_req_ready,
    output logic [ADDR_WIDTH-1:0]   port_addr,
    output logic                    port_write,
    output logic [WIDTH-1:0]        port_wdata,
    output logic [WIDTH/8-1:0]      port_wmask,
    input  logic [3:0]              port_rsp_valid,
    input  logic [4*WIDTH-1:0]      port_rdata
);

    // Timer must be able to hold TIMEOUT: an accept on the last ISSUE cycle still increments it.
    localparam int TIMER_W = $clog2(TIMEOUT + 1);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT - 1);

    demux_state_t            state_reg;
    port_sel_t               sel_reg;
    logic [TIMER_W-1:0]      timer_reg;
    logic [ADDR_WIDTH-1:0]   addr_reg;
    logic                    write_reg;
    logic [WIDTH-1:0]        wdata_reg;
    logic [WIDTH/8-1:0]      wmask_reg;
    logic                    rsp_valid_reg;
    logic                    rsp_error_reg;
    logic [WIDTH-1:0]        rsp_rdata_reg;

    logic [WIDTH-1:0]        rdata_slice [4];
    logic [WIDTH-1:0]        rdata_sel;
    logic                    timer_expired;

    // Unpack the per-target read data buses.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_slice
            assign rdata_slice[gi] = port_rdata[gi*WIDTH +: WIDTH];
        end
    endgenerate

    multiplexer4 #(
        .WIDTH (WIDTH)
    ) u_rdata_mux (
        .in0 (rdata_slice[0]),
        .in1 (rdata_slice[1]),
        .in2 (rdata_slice[2]),
        .in3 (rdata_slice[3]),
        .sel (sel_reg),
        .out (rdata_sel)
    );

    // ">=" rather than "==": an accept on the final ISSUE cycle lands in WAIT_RSP already past the limit.
    assign timer_expired = (timer_reg >= TIMER_LAST);

    // Request strobe only while issuing; everything else is straight from registers.
    assign req_ready      = (state_reg == IDLE);
    assign port_req_valid = (state_reg == ISSUE) ? sel_onehot(sel_reg) : 4'b0000;
    assign port_addr      = addr_reg;
    assign port_write     = write_reg;
    assign port_wdata     = wdata_reg;
    assign port_wmask     = wmask_reg;
    assign rsp_valid      = rsp_valid_reg;
    assign rsp_error      = rsp_error_reg;
    assign rsp_rdata      = rsp_rdata_reg;

    // Transaction FSM: capture, issue to the selected target, wait for its response or time out.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg     <= IDLE;
            sel_reg       <= PORT_ROM;
            timer_reg     <= '0;
            addr_reg      <= '0;
            write_reg     <= 1'b0;
            wdata_reg     <= '0;
            wmask_reg     <= '0;
            rsp_valid_reg <= 1'b0;
            rsp_error_reg <= 1'b0;
            rsp_rdata_reg <= '0;
        end else begin
            rsp_valid_reg <= 1'b0;
            rsp_error_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (req_valid) begin
                        addr_reg  <= req_addr;
                        write_reg <= req_write;
                        wdata_reg <= req_wdata;
                        wmask_reg <= req_wmask;
                        sel_reg   <= req_addr[SEL_LSB +: 2];
                        timer_reg <= '0;
                        state_reg <= ISSUE;
                    end
                end
                ISSUE: begin
                    timer_reg <= timer_reg + 1'b1;
                    if (port_req_ready[sel_reg]) begin
                        state_reg <= WAIT_RSP;
                    end else if (timer_expired) begin
                        rsp_valid_reg <= 1'b1;
                        rsp_error_reg <= 1'b1;
                        rsp_rdata_reg <= '0;
                        state_reg     <= IDLE;
                    end
                end
                WAIT_RSP: begin
                    timer_reg <= timer_reg + 1'b1;
                    // A real response beats a timeout landing on the same cycle.
                    if (port_rsp_valid[sel_reg]) begin
                        rsp_valid_reg <= 1'b1;
                        rsp_rdata_reg <= write_reg ? '0 : rdata_sel;
                        state_reg     <= IDLE;
                    end else if (timer_expired) begin
                        rsp_valid_reg <= 1'b1;
                        rsp_error_reg <= 1'b1;
                        rsp_rdata_reg <= '0;
                        state_reg     <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_demux4.sv
// Scoreboard bench for bus_demux4: expected responses queued at request time, popped on rsp_valid.
module tb_bus_demux4;

    localparam int WIDTH   = 32;
    localparam int AW      = 32;
    localparam int TIMEOUT = 15;

    logic             clock = 1'b0;
    logic             reset;
    logic             req_valid;
    logic             req_ready;
    logic [AW-1:0]    req_addr;
    logic             req_write;
    logic [WIDTH-1:0] req_wdata;
    logic [3:0]       req_wmask;
    logic             rsp_valid;
    logic [WIDTH-1:0] rsp_rdata;
    logic             rsp_error;
    logic [3:0]       port_req_valid;
    logic [3:0]       port_req_ready;
    logic [AW-1:0]    port_addr;
    logic             port_write;
    logic [WIDTH-1:0] port_wdata;
    logic [3:0]       port_wmask;
    logic [3:0]       port_rsp_valid;
    logic [4*WIDTH-1:0] port_rdata;

    typedef struct {
        logic [WIDTH-1:0] rdata;
        logic             err;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_rsp    = 0;
    int   n_pushed = 0;

    always #5 clock = ~clock;

    bus_demux4 #(
        .WIDTH      (WIDTH),
        .ADDR_WIDTH (AW),
        .SEL_LSB    (28),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_addr       (req_addr),
        .req_write      (req_write),
        .req_wdata      (req_wdata),
        .req_wmask      (req_wmask),
        .rsp_valid      (rsp_valid),
        .rsp_rdata      (rsp_rdata),
        .rsp_error      (rsp_error),
        .port_req_valid (port_req_valid),
        .port_req_ready (port_req_ready),
        .port_addr      (port_addr),
        .port_write     (port_write),
        .port_wdata     (port_wdata),
        .port_wmask     (port_wmask),
        .port_rsp_valid (port_rsp_valid),
        .port_rdata     (port_rdata)
    );

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end else begin
            $display("ok   %s: %0h", tag, act);
        end
    endtask

    // Advance one clock; return 1ns after the edge so registered outputs have settled.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic push_exp(input logic [WIDTH-1:0] rdata, input logic err);
        exp_t e;
        e.rdata = rdata;
        e.err   = err;
        exp_q.push_back(e);
        n_pushed++;
    endtask

    task automatic drive_req(input logic [AW-1:0] addr, input logic wr,
                             input logic [WIDTH-1:0] wdata, input logic [3:0] wmask);
        req_valid = 1'b1;
        req_addr  = addr;
        req_write = wr;
        req_wdata = wdata;
        req_wmask = wmask;
    endtask

    task automatic clear_ports();
        port_req_ready = 4'b0000;
        port_rsp_valid = 4'b0000;
        port_rdata     = '0;
    endtask

    // Response monitor: every rsp_valid pulse must match the oldest expected response.
    always @(negedge clock) begin
        if (rsp_valid === 1'b1) begin
            n_rsp++;
            if (exp_q.size() == 0) begin
                check_eq("unexpected_rsp", 64'(rsp_valid), 64'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check_eq("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
                check_eq("rsp_error", 64'(rsp_error), 64'(e.err));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int k;
        reset     = 1'b1;
        req_valid = 1'b0;
        req_addr  = '0;
        req_write = 1'b0;
        req_wdata = '0;
        req_wmask = '0;
        clear_ports();
        repeat (3) tick();

        // Reset state
        check_eq("reset_req_ready", 64'(req_ready), 64'd1);
        check_eq("reset_rsp_valid", 64'(rsp_valid), 64'd0);
        check_eq("reset_port_req_valid", 64'(port_req_valid), 64'd0);
        check_eq("reset_port_addr", 64'(port_addr), 64'd0);
        check_eq("reset_rsp_rdata", 64'(rsp_rdata), 64'd0);
        reset = 1'b0;
        tick();

        // 1: minimum-latency read from port 1
        drive_req(32'h1000_0040, 1'b0, 32'h0, 4'hF);
        push_exp(32'hDEAD_BEEF, 1'b0);
        tick();
        req_valid = 1'b0;
        check_eq("t1_port_req_valid", 64'(port_req_valid), 64'b0010);
        check_eq("t1_req_ready_busy", 64'(req_ready), 64'd0);
        check_eq("t1_port_addr", 64'(port_addr), 64'h1000_0040);
        port_req_ready = 4'b0010;
        tick();
        clear_ports();
        check_eq("t1_wait_no_strobe", 64'(port_req_valid), 64'd0);
        port_rsp_valid = 4'b0010;
        port_rdata[1*WIDTH +: WIDTH] = 32'hDEAD_BEEF;
        tick();
        clear_ports();
        check_eq("t1_rsp_valid", 64'(rsp_valid), 64'd1);
        check_eq("t1_req_ready_with_rsp", 64'(req_ready), 64'd1);
        tick();
        check_eq("t1_rsp_pulse_one_cycle", 64'(rsp_valid), 64'd0);

        // 2: write to port 2, captured fields stable while ISSUE waits
        drive_req(32'h2000_0004, 1'b1, 32'h1234_5678, 4'b0011);
        push_exp(32'h0, 1'b0);
        tick();
        drive_req(32'hFFFF_FFFC, 1'b0, 32'hFFFF_FFFF, 4'b1100);
        req_valid = 1'b0;
        repeat (3) tick();
        check_eq("t2_port_req_valid", 64'(port_req_valid), 64'b0100);
        check_eq("t2_port_addr", 64'(port_addr), 64'h2000_0004);
        check_eq("t2_port_wdata", 64'(port_wdata), 64'h1234_5678);
        check_eq("t2_port_wmask", 64'(port_wmask), 64'b0011);
        check_eq("t2_port_write", 64'(port_write), 64'd1);
        port_req_ready = 4'b0100;
        tick();
        clear_ports();
        port_rsp_valid = 4'b0100;
        port_rdata[2*WIDTH +: WIDTH] = 32'hAAAA_5555;
        tick();
        clear_ports();
        check_eq("t2_rsp_valid", 64'(rsp_valid), 64'd1);
        tick();
        check_eq("t2_rsp_single_pulse", 64'(rsp_valid), 64'd0);

        // 3: timeout on port 3
        drive_req(32'h3000_0000, 1'b0, 32'h0, 4'hF);
        push_exp(32'h0, 1'b1);
        tick();
        req_valid = 1'b0;
        k = 0;
        for (int i = 1; i <= TIMEOUT + 5; i++) begin
            tick();
            if (rsp_valid === 1'b1) begin
                k = i;
                break;
            end
        end
        check_eq("t3_timeout_latency", 64'(k), 64'(TIMEOUT));
        check_eq("t3_req_ready_after", 64'(req_ready), 64'd1);
        tick();

        // 4: stray ready/response strobes from ports 0 and 2 are ignored
        drive_req(32'h1000_0000, 1'b0, 32'h0, 4'hF);
        push_exp(32'hCAFE_F00D, 1'b0);
        tick();
        req_valid = 1'b0;
        port_req_ready = 4'b0101;
        port_rsp_valid = 4'b0101;
        port_rdata[0*WIDTH +: WIDTH] = 32'hFFFF_FFFF;
        port_rdata[2*WIDTH +: WIDTH] = 32'hFFFF_FFFF;
        tick();
        check_eq("t4_still_issue", 64'(port_req_valid), 64'b0010);
        port_req_ready = 4'b0111;
        tick();
        port_req_ready = 4'b0101;
        tick();
        check_eq("t4_no_early_rsp", 64'(rsp_valid), 64'd0);
        port_rsp_valid = 4'b0111;
        port_rdata[1*WIDTH +: WIDTH] = 32'hCAFE_F00D;
        tick();
        clear_ports();
        check_eq("t4_rsp_valid", 64'(rsp_valid), 64'd1);
        tick();

        // 5: back-to-back, second request accepted in the rsp_valid cycle
        drive_req(32'h0000_0100, 1'b0, 32'h0, 4'hF);
        push_exp(32'h0BAD_F00D, 1'b0);
        tick();
        req_valid = 1'b0;
        port_req_ready = 4'b0001;
        tick();
        clear_ports();
        port_rsp_valid = 4'b0001;
        port_rdata[0*WIDTH +: WIDTH] = 32'h0BAD_F00D;
        tick();
        clear_ports();
        check_eq("t5_first_rsp", 64'(rsp_valid), 64'd1);
        check_eq("t5_ready_in_rsp_cycle", 64'(req_ready), 64'd1);
        drive_req(32'h3000_0010, 1'b0, 32'h0, 4'hF);
        push_exp(32'h5555_AAAA, 1'b0);
        tick();
        req_valid = 1'b0;
        check_eq("t5_second_issue", 64'(port_req_valid), 64'b1000);
        port_req_ready = 4'b1000;
        tick();
        clear_ports();
        port_rsp_valid = 4'b1000;
        port_rdata[3*WIDTH +: WIDTH] = 32'h5555_AAAA;
        tick();
        clear_ports();
        check_eq("t5_second_rsp", 64'(rsp_valid), 64'd1);
        tick();

        // 6: reset while in WAIT_RSP, late response afterwards is ignored
        drive_req(32'h1000_0080, 1'b1, 32'h7777_7777, 4'hF);
        tick();
        req_valid = 1'b0;
        port_req_ready = 4'b0010;
        tick();
        clear_ports();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        port_rsp_valid = 4'b0010;
        port_rdata[1*WIDTH +: WIDTH] = 32'h1111_2222;
        tick();
        clear_ports();
        check_eq("t6_no_rsp", 64'(rsp_valid), 64'd0);
        check_eq("t6_req_ready", 64'(req_ready), 64'd1);
        check_eq("t6_port_addr", 64'(port_addr), 64'd0);
        check_eq("t6_port_wdata", 64'(port_wdata), 64'd0);
        check_eq("t6_port_write", 64'(port_write), 64'd0);
        check_eq("t6_port_req_valid", 64'(port_req_valid), 64'd0);
        tick();
        check_eq("t6_still_no_rsp", 64'(rsp_valid), 64'd0);
        repeat (2) tick();

        // Scoreboard drained and response count matches what was issued
        check_eq("sb_empty", 64'(exp_q.size()), 64'd0);
        check_eq("rsp_count", 64'(n_rsp), 64'(n_pushed));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
